// File: rtl/qspi_prog_sequencer.sv
// qspi_prog_sequencer: drives a memory-mapped QSPI controller over an AHB-Lite master port
// to optionally erase a 4 KiB sector and then program up to one 256-byte page from a byte
// stream. Each bus access is a single NONSEQ transfer; the bus is never pipelined.
module qspi_prog_sequencer #(
    parameter logic [31:0] REG_BASE   = 32'h00010000,
    parameter logic [15:0] POLL_LIMIT = 16'd65535
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        start,
    input  logic [23:0] cfg_addr,
    input  logic [8:0]  cfg_len,
    input  logic        skip_erase,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic [31:0] HRDATA,
    input  logic        HRESP
);

    localparam logic [31:0] OFF_CTRL   = 32'h00;
    localparam logic [31:0] OFF_STATUS = 32'h04;
    localparam logic [31:0] OFF_ADDR   = 32'h08;
    localparam logic [31:0] OFF_LEN    = 32'h0C;
    localparam logic [31:0] OFF_DATA   = 32'h10;

    localparam logic [2:0] OP_WREN = 3'd0;
    localparam logic [2:0] OP_PP   = 3'd3;
    localparam logic [2:0] OP_SE   = 3'd4;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    typedef enum logic [3:0] {
        IDLE, CHECK, WREN_E, ADDR_E, CMD_E, POLL_E, WREN_P, ADDR_P, LEN_P, FILL, CMD_P,
        POLL_P, DONE, ERR
    } state_t;

    // Where the single outstanding bus transfer currently is.
    typedef enum logic [1:0] {
        BUS_IDLE, BUS_ADDR, BUS_DATA
    } phase_t;

    function automatic logic [31:0] ctrl_word(input logic [2:0] op);
        return {24'b0, 1'b1, 4'b0, op};
    endfunction

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic        poll_q, poll_d;          // WREN states: write done, now polling STATUS
    logic [15:0] poll_cnt_q, poll_cnt_d;
    logic [8:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] addr_q, addr_d;
    logic [8:0]  len_q, len_d;
    logic        skip_q, skip_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [31:0] haddr_q, haddr_d;
    logic [1:0]  htrans_q, htrans_d;
    logic        hwrite_q, hwrite_d;
    logic [31:0] hwdata_q, hwdata_d;

    logic        req, req_write, poll_read, xfer_ok, xfer_err;
    logic [31:0] req_off, req_data;
    logic [9:0]  len_sum;
    logic        unused_rdata;

    assign unused_rdata = ^HRDATA[31:1];

    // State and bus output registers; reset abandons any sequence in flight.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q    <= IDLE;
            phase_q    <= BUS_IDLE;
            poll_q     <= 1'b0;
            poll_cnt_q <= '0;
            byte_cnt_q <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            skip_q     <= 1'b0;
            err_code_q <= 2'd0;
            haddr_q    <= '0;
            htrans_q   <= TRANS_IDLE;
            hwrite_q   <= 1'b0;
            hwdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            poll_q     <= poll_d;
            poll_cnt_q <= poll_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            skip_q     <= skip_d;
            err_code_q <= err_code_d;
            haddr_q    <= haddr_d;
            htrans_q   <= htrans_d;
            hwrite_q   <= hwrite_d;
            hwdata_q   <= hwdata_d;
        end
    end

    // Next-state: bus phase tracking, sequence steps, poll timeout, bus error and launch.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        poll_d     = poll_q;
        poll_cnt_d = poll_cnt_q;
        byte_cnt_d = byte_cnt_q;
        addr_d     = addr_q;
        len_d      = len_q;
        skip_d     = skip_q;
        err_code_d = err_code_q;
        haddr_d    = haddr_q;
        htrans_d   = htrans_q;
        hwrite_d   = hwrite_q;
        hwdata_d   = hwdata_q;
        req        = 1'b0;
        req_write  = 1'b0;
        req_off    = OFF_CTRL;
        req_data   = '0;
        poll_read  = 1'b0;
        xfer_ok    = 1'b0;
        xfer_err   = 1'b0;
        wr_ready   = 1'b0;
        len_sum    = {2'b0, addr_q[7:0]} + {1'b0, len_q};

        unique case (phase_q)
            BUS_ADDR: begin
                if (HREADY) begin
                    phase_d  = BUS_DATA;
                    htrans_d = TRANS_IDLE;
                end
            end
            BUS_DATA: begin
                if (HRESP) begin
                    xfer_err = 1'b1;
                    phase_d  = BUS_IDLE;
                end else if (HREADY) begin
                    xfer_ok = 1'b1;
                    phase_d = BUS_IDLE;
                end
            end
            default: ;
        endcase

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d     = cfg_addr;
                    len_d      = cfg_len;
                    skip_d     = skip_erase;
                    err_code_d = 2'd0;
                    poll_d     = 1'b0;
                    poll_cnt_d = '0;
                    byte_cnt_d = '0;
                    state_d    = CHECK;
                end
            end
            CHECK: begin
                if (len_q == 9'd0 || len_q > 9'd256 || len_sum > 10'd256) begin
                    err_code_d = 2'd1;
                    state_d    = ERR;
                end else begin
                    state_d = skip_q ? WREN_P : WREN_E;
                end
            end
            WREN_E, WREN_P: begin
                req = 1'b1;
                if (!poll_q) begin
                    req_write = 1'b1;
                    req_data  = ctrl_word(OP_WREN);
                    if (xfer_ok) begin
                        poll_d     = 1'b1;
                        poll_cnt_d = '0;
                    end
                end else begin
                    req_off   = OFF_STATUS;
                    poll_read = 1'b1;
                    if (xfer_ok && !HRDATA[0]) begin
                        poll_d  = 1'b0;
                        state_d = (state_q == WREN_E) ? ADDR_E : ADDR_P;
                    end
                end
            end
            ADDR_E: begin
                req       = 1'b1;
                req_write = 1'b1;
                req_off   = OFF_ADDR;
                req_data  = {8'b0, addr_q[23:12], 12'b0};
                if (xfer_ok) state_d = CMD_E;
            end
            CMD_E, CMD_P: begin
                req       = 1'b1;
                req_write = 1'b1;
                req_data  = ctrl_word((state_q == CMD_E) ? OP_SE : OP_PP);
                if (xfer_ok) begin
                    poll_cnt_d = '0;
                    state_d    = (state_q == CMD_E) ? POLL_E : POLL_P;
                end
            end
            POLL_E, POLL_P: begin
                req       = 1'b1;
                req_off   = OFF_STATUS;
                poll_read = 1'b1;
                if (xfer_ok && !HRDATA[0]) state_d = (state_q == POLL_E) ? WREN_P : DONE;
            end
            ADDR_P: begin
                req       = 1'b1;
                req_write = 1'b1;
                req_off   = OFF_ADDR;
                req_data  = {8'b0, addr_q};
                if (xfer_ok) state_d = LEN_P;
            end
            LEN_P: begin
                req       = 1'b1;
                req_write = 1'b1;
                req_off   = OFF_LEN;
                req_data  = {23'b0, len_q};
                if (xfer_ok) state_d = FILL;
            end
            FILL: begin
                // A byte is only taken when its DATA write can be launched immediately.
                wr_ready = (phase_q == BUS_IDLE) && (byte_cnt_q != len_q);
                if (wr_valid && wr_ready) begin
                    req        = 1'b1;
                    req_write  = 1'b1;
                    req_off    = OFF_DATA;
                    req_data   = {24'b0, wr_data};
                    byte_cnt_d = byte_cnt_q + 9'd1;
                end
                if (xfer_ok && byte_cnt_q == len_q) state_d = CMD_P;
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A STATUS read still showing busy consumes one poll of the current command's budget.
        if (poll_read && xfer_ok && HRDATA[0]) begin
            if (poll_cnt_q == POLL_LIMIT - 16'd1) begin
                err_code_d = 2'd2;
                state_d    = ERR;
            end else begin
                poll_cnt_d = poll_cnt_q + 16'd1;
            end
        end

        if (xfer_err) begin
            err_code_d = 2'd3;
            state_d    = ERR;
        end

        // Launch a new single transfer only once the previous one has fully completed.
        if (req && phase_q == BUS_IDLE) begin
            phase_d  = BUS_ADDR;
            htrans_d = TRANS_NONSEQ;
            haddr_d  = REG_BASE + req_off;
            hwrite_d = req_write;
            hwdata_d = req_write ? req_data : 32'h0;
        end
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        busy     = !(state_q == IDLE || state_q == DONE || state_q == ERR);
        done     = (state_q == DONE);
        error    = (state_q == ERR);
        err_code = err_code_q;
        HADDR    = haddr_q;
        HTRANS   = htrans_q;
        HWRITE   = hwrite_q;
        HWDATA   = hwdata_q;
    end

endmodule

// File: tb/tb_qspi_prog_sequencer.sv
// tb_qspi_prog_sequencer: directed scenarios against a bus-slave model of the QSPI controller.
// The expected register-access list for each command is built from the command parameters;
// every completed transfer is compared against it as it happens.
module tb_qspi_prog_sequencer;

    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam int          LIMIT = 8;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        start = 1'b0;
    logic [23:0] cfg_addr = '0;
    logic [8:0]  cfg_len = '0;
    logic        skip_erase = 1'b0;
    logic [7:0]  wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready, busy, done, error;
    logic [1:0]  err_code;
    logic [31:0] HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic        HREADY = 1'b1;
    logic [31:0] HRDATA = '0;
    logic        HRESP = 1'b0;

    always #5 HCLK = ~HCLK;

    qspi_prog_sequencer #(
        .REG_BASE   (BASE),
        .POLL_LIMIT (16'(LIMIT))
    ) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .start      (start),
        .cfg_addr   (cfg_addr),
        .cfg_len    (cfg_len),
        .skip_erase (skip_erase),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code),
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HWRITE     (HWRITE),
        .HWDATA     (HWDATA),
        .HREADY     (HREADY),
        .HRDATA     (HRDATA),
        .HRESP      (HRESP)
    );

    int n_checks = 0;
    int n_fail = 0;

    // Expected accesses (written by the stimulus), consumed through exp_ptr by the monitor.
    logic [31:0] exp_addr[$];
    logic        exp_write[$];
    logic [31:0] exp_data[$];
    int          exp_ptr = 0;
    // Observed accesses, in completion order.
    logic [31:0] obs_addr[$];
    logic        obs_write[$];
    logic [31:0] obs_data[$];

    // Slave / stream configuration.
    int          busy_n = 1;
    bit          stuck = 1'b0;
    bit          err_on_addr = 1'b0;
    int          wait_pct = 0;
    bit          toggle_valid = 1'b0;
    logic [7:0]  bytes[$];

    // Monitor-private state.
    int          status_left = 0;
    bit          dphase = 1'b0;
    bit          err_tail = 1'b0;
    logic [31:0] dp_addr = '0;
    logic        dp_write = 1'b0;
    int          byte_idx = 0;
    bit          pend_acc = 1'b0;
    int          done_total = 0;
    int          error_total = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    function automatic void push(input logic w, input logic [31:0] off, input logic [31:0] d);
        exp_addr.push_back(BASE + off);
        exp_write.push_back(w);
        exp_data.push_back(d);
    endfunction

    function automatic void push_polls(input int n);
        for (int i = 0; i < n; i++) push(1'b0, 32'h4, 32'h0);
    endfunction

    // Access list for one legal command whose STATUS polls each take 'polls' reads.
    function automatic void model_seq(input logic [23:0] a, input int len, input bit skip,
                                      input int polls);
        if (!skip) begin
            push(1'b1, 32'h0, 32'h80);
            push_polls(polls);
            push(1'b1, 32'h8, {8'h00, a} & 32'h00FF_F000);
            push(1'b1, 32'h0, 32'h84);
            push_polls(polls);
        end
        push(1'b1, 32'h0, 32'h80);
        push_polls(polls);
        push(1'b1, 32'h8, {8'h00, a});
        push(1'b1, 32'hC, 32'(len));
        for (int i = 0; i < len; i++) push(1'b1, 32'h10, {24'h0, bytes[i]});
        push(1'b1, 32'h0, 32'h83);
        push_polls(polls);
    endfunction

    function automatic void log_xfer(input logic [31:0] a, input logic w, input logic [31:0] d);
        obs_addr.push_back(a);
        obs_write.push_back(w);
        obs_data.push_back(d);
        if (exp_ptr >= exp_addr.size()) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_xfer: got addr 0x%08h write %0d data 0x%08h, expected none",
                     a, w, d);
        end else begin
            check("xfer_addr", a, exp_addr[exp_ptr]);
            check("xfer_write", 32'(w), 32'(exp_write[exp_ptr]));
            if (w) check("xfer_data", d, exp_data[exp_ptr]);
            exp_ptr++;
        end
    endfunction

    function automatic int count_obs(input int from, input logic [31:0] a);
        int n = 0;
        for (int i = from; i < obs_addr.size(); i++) if (obs_addr[i] == a) n++;
        return n;
    endfunction

    // Compare process: slave responses, stream driver and per-cycle output checks.
    always @(negedge HCLK) begin
        if (HRESET) begin
            dphase = 1'b0;
            err_tail = 1'b0;
            HREADY = 1'b1;
            HRESP = 1'b0;
            HRDATA = '0;
            wr_valid = 1'b0;
            byte_idx = 0;
            pend_acc = 1'b0;
            status_left = 0;
            exp_ptr = exp_addr.size();
        end else begin
            check("htrans_legal", 32'(HTRANS == 2'b00 || HTRANS == 2'b10), 32'd1);
            check("wr_ready_gate", 32'(wr_ready && (!busy || dphase || HTRANS != 2'b00)), 32'd0);
            check("pulse_vs_busy", 32'((done || error) && busy), 32'd0);
            check("done_and_error", 32'(done && error), 32'd0);
            done_total += int'(done);
            error_total += int'(error);

            if (!busy) begin
                byte_idx = 0;
                pend_acc = 1'b0;
            end
            if (pend_acc) byte_idx++;
            if (byte_idx < bytes.size()) begin
                wr_data = bytes[byte_idx];
                wr_valid = toggle_valid ? ($urandom_range(0, 1) != 0) : 1'b1;
            end else begin
                wr_valid = 1'b0;
            end
            pend_acc = wr_valid && wr_ready;

            HREADY = 1'b1;
            HRESP = 1'b0;
            if (err_tail) begin
                HRESP = 1'b1;
                err_tail = 1'b0;
            end else if (dphase) begin
                check("htrans_in_data", 32'(HTRANS), 32'd0);
                if (wait_pct != 0 && $urandom_range(0, 99) < wait_pct) begin
                    HREADY = 1'b0;
                end else if (err_on_addr && dp_addr == BASE + 32'h8) begin
                    HRESP = 1'b1;
                    HREADY = 1'b0;
                    err_tail = 1'b1;
                    dphase = 1'b0;
                    log_xfer(dp_addr, dp_write, HWDATA);
                end else begin
                    dphase = 1'b0;
                    if (dp_write) begin
                        log_xfer(dp_addr, 1'b1, HWDATA);
                        if (dp_addr == BASE) status_left = busy_n;
                    end else begin
                        HRDATA = {31'h0, stuck || status_left > 0};
                        if (status_left > 0) status_left--;
                        log_xfer(dp_addr, 1'b0, 32'h0);
                    end
                end
            end else if (HTRANS == 2'b10) begin
                dphase = 1'b1;
                dp_addr = HADDR;
                dp_write = HWRITE;
            end
        end
    end

    int obs_base = 0;

    task automatic start_cmd(input logic [23:0] a, input logic [8:0] len, input bit skip);
        @(negedge HCLK);
        cfg_addr = a;
        cfg_len = len;
        skip_erase = skip;
        start = 1'b1;
        @(negedge HCLK);
        start = 1'b0;
    endtask

    task automatic run(input logic [23:0] a, input logic [8:0] len, input bit skip,
                       input bit ok, input logic [1:0] code, input string tag);
        int d0, e0, n;
        d0 = done_total;
        e0 = error_total;
        obs_base = obs_addr.size();
        start_cmd(a, len, skip);
        check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        n = 0;
        while (!(done || error) && n < 20000) begin
            @(negedge HCLK);
            n++;
        end
        if (!(done || error)) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got no done/error in %0d cycles, expected one", tag, n);
        end
        repeat (12) @(negedge HCLK);
        check({tag, "_done_pulses"}, 32'(done_total - d0), ok ? 32'd1 : 32'd0);
        check({tag, "_error_pulses"}, 32'(error_total - e0), ok ? 32'd0 : 32'd1);
        check({tag, "_err_code"}, 32'(err_code), 32'(code));
        check({tag, "_pending_expected"}, 32'(exp_addr.size() - exp_ptr), 32'd0);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_err_code"}, 32'(err_code), 32'd0);
        check({tag, "_wr_ready"}, 32'(wr_ready), 32'd0);
        check({tag, "_htrans"}, 32'(HTRANS), 32'd0);
        check({tag, "_hwrite"}, 32'(HWRITE), 32'd0);
        check({tag, "_haddr"}, HADDR, 32'd0);
        check({tag, "_hwdata"}, HWDATA, 32'd0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge HCLK);
        check_reset_outputs("reset");
        HRESET = 1'b0;

        // Full erase + program, 16 bytes, one busy STATUS per poll.
        busy_n = 1;
        bytes.delete();
        for (int i = 0; i < 16; i++) bytes.push_back(8'hA0 + 8'(i));
        model_seq(24'h001000, 16, 1'b0, busy_n + 1);
        run(24'h001000, 9'd16, 1'b0, 1'b1, 2'd0, "full");
        check("full_xfer_count", 32'(obs_addr.size() - obs_base), 32'd31);
        check("full_first_ctrl", obs_data[obs_base], 32'h0000_0080);
        check("full_erase_addr_reg", obs_addr[obs_base + 3], 32'h0001_0008);
        check("full_erase_addr", obs_data[obs_base + 3], 32'h0000_1000);
        check("full_erase_cmd", obs_data[obs_base + 4], 32'h0000_0084);
        check("full_len", obs_data[obs_base + 11], 32'h0000_0010);
        check("full_first_byte", obs_data[obs_base + 12], 32'h0000_00A0);
        check("full_last_byte", obs_data[obs_base + 27], 32'h0000_00AF);
        check("full_pp_cmd", obs_data[obs_base + 28], 32'h0000_0083);

        // Illegal lengths: nothing reaches the bus.
        run(24'h001000, 9'd0, 1'b0, 1'b0, 2'd1, "len_zero");
        check("len_zero_xfers", 32'(obs_addr.size() - obs_base), 32'd0);
        run(24'h0010F8, 9'd16, 1'b0, 1'b0, 2'd1, "page_cross");
        check("page_cross_xfers", 32'(obs_addr.size() - obs_base), 32'd0);
        run(24'h000000, 9'd257, 1'b1, 1'b0, 2'd1, "len_257");
        check("len_257_xfers", 32'(obs_addr.size() - obs_base), 32'd0);

        // Exactly filling to the page end is legal.
        busy_n = 0;
        model_seq(24'h0030F0, 16, 1'b1, busy_n + 1);
        run(24'h0030F0, 9'd16, 1'b1, 1'b1, 2'd0, "page_end");

        // STATUS stuck busy: POLL_LIMIT reads then timeout.
        stuck = 1'b1;
        push(1'b1, 32'h0, 32'h80);
        push_polls(LIMIT);
        run(24'h001000, 9'd16, 1'b0, 1'b0, 2'd2, "stuck");
        check("stuck_status_reads", 32'(count_obs(obs_base, BASE + 32'h4)), 32'd8);
        stuck = 1'b0;

        // Bus error on the erase ADDR write.
        busy_n = 0;
        err_on_addr = 1'b1;
        push(1'b1, 32'h0, 32'h80);
        push_polls(1);
        push(1'b1, 32'h8, 32'h0000_5000);
        run(24'h005123, 9'd4, 1'b0, 1'b0, 2'd3, "hresp");
        check("hresp_xfer_count", 32'(obs_addr.size() - obs_base), 32'd3);
        err_on_addr = 1'b0;

        // Whole page, no erase, stalling stream and slave wait states.
        busy_n = 2;
        wait_pct = 20;
        toggle_valid = 1'b1;
        bytes.delete();
        for (int i = 0; i < 256; i++) bytes.push_back(8'((i * 37 + 11) & 255));
        model_seq(24'h002000, 256, 1'b1, busy_n + 1);
        run(24'h002000, 9'd256, 1'b1, 1'b1, 2'd0, "page256");
        check("page256_data_writes", 32'(count_obs(obs_base, BASE + 32'h10)), 32'd256);
        check("page256_addr_writes", 32'(count_obs(obs_base, BASE + 32'h8)), 32'd1);
        wait_pct = 0;
        toggle_valid = 1'b0;

        // Reset in the middle of FILL, then a clean full command.
        busy_n = 0;
        bytes.delete();
        for (int i = 0; i < 8; i++) bytes.push_back(8'h50 + 8'(i));
        model_seq(24'h004000, 8, 1'b1, 1);
        obs_base = obs_addr.size();
        start_cmd(24'h004000, 9'd8, 1'b1);
        n = 0;
        while (count_obs(obs_base, BASE + 32'h10) < 3 && n < 2000) begin
            @(negedge HCLK);
            n++;
        end
        check("rst_fill_reached", 32'(count_obs(obs_base, BASE + 32'h10) >= 3), 32'd1);
        #2 HRESET = 1'b1;
        @(negedge HCLK);
        check_reset_outputs("midreset");
        @(negedge HCLK);
        #2 HRESET = 1'b0;
        obs_base = obs_addr.size();
        repeat (20) @(negedge HCLK);
        check("post_reset_idle_xfers", 32'(obs_addr.size() - obs_base), 32'd0);
        check("post_reset_busy", 32'(busy), 32'd0);
        bytes.delete();
        for (int i = 0; i < 4; i++) bytes.push_back(8'h60 + 8'(i));
        model_seq(24'h007004, 4, 1'b0, 1);
        run(24'h007004, 9'd4, 1'b0, 1'b1, 2'd0, "after_reset");
        check("after_reset_xfer_count", 32'(obs_addr.size() - obs_base), 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
